// File: rtl/custom_insn_issuer.sv
// Host-side issuer for the heap custom-instruction unit: buffers push/pop commands,
// pulses each one onto the unit's rd/in_data pins and returns pop results or timeouts.
module custom_insn_issuer #(
    parameter int         DATA_W        = 32,
    parameter int         CMD_DEPTH     = 4,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         POP_TIMEOUT   = 16,
    parameter logic [4:0] IDLE_RD       = 5'd31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [4:0]        cu_rd,
    output logic [DATA_W-1:0] cu_in_data,
    input  logic              cu_out_v,
    input  logic [4:0]        cu_out_rd,
    input  logic [DATA_W-1:0] cu_out_data,
    output logic              busy,
    output logic [7:0]        stray_cnt
);

    localparam int PTR_W   = $clog2(CMD_DEPTH);
    localparam int CNT_MAX = (POP_TIMEOUT > SETTLE_CYCLES) ? POP_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(POP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RESP,
        S_SETTLE
    } state_t;

    state_t            r_state;
    logic              r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_cu_rd;
    logic [DATA_W-1:0] r_cu_in_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [7:0]        r_stray_cnt;

    // Each entry is {op, data}; the extra pointer bit separates full from empty.
    logic [DATA_W:0]   r_fifo [CMD_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [DATA_W:0]   w_head;
    logic              w_reply;
    logic              w_stray;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_wr_en = cmd_valid && !w_full;
    assign w_rd_en = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign w_reply = cu_out_v && (cu_out_rd == 5'd1);
    assign w_stray = cu_out_v && !((r_state == S_WAIT_RSP) && (cu_out_rd == 5'd1));

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= {cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 1'b0;
            r_cnt        <= '0;
            r_cu_rd      <= IDLE_RD;
            r_cu_in_data <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_op         <= w_head[DATA_W];
                        r_cu_rd      <= {4'b0, w_head[DATA_W]};
                        r_cu_in_data <= w_head[DATA_W] ? '0 : w_head[DATA_W-1:0];
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cu_rd      <= IDLE_RD;
                    r_cu_in_data <= '0;
                    r_cnt        <= '0;
                    r_state      <= r_op ? S_WAIT_RSP : S_SETTLE;
                end
                S_WAIT_RSP: begin
                    // A reply arriving on the last counted cycle beats the timeout.
                    if (w_reply) begin
                        r_rsp_data  <= cu_out_data;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stray_cnt <= '0;
        end else if (w_stray && (r_stray_cnt != 8'hFF)) begin
            r_stray_cnt <= r_stray_cnt + 8'd1;
        end
    end

    assign cmd_ready  = !w_full;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign cu_rd      = r_cu_rd;
    assign cu_in_data = r_cu_in_data;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign stray_cnt  = r_stray_cnt;

endmodule

// File: tb/tb_custom_insn_issuer.sv
// Scoreboard bench for custom_insn_issuer with a behavioural max-heap unit model.
module tb_custom_insn_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  cu_rd;
    logic [31:0] cu_in_data;
    logic        cu_out_v;
    logic [4:0]  cu_out_rd;
    logic [31:0] cu_out_data;
    logic        busy;
    logic [7:0]  stray_cnt;

    logic        mdl_v = 1'b0;
    logic [4:0]  mdl_rd = 5'd0;
    logic [31:0] mdl_data = '0;
    logic        inj_v = 1'b0;

    assign cu_out_v    = mdl_v | inj_v;
    assign cu_out_rd   = inj_v ? 5'd1 : mdl_rd;
    assign cu_out_data = inj_v ? 32'h0000_0BAD : mdl_data;

    custom_insn_issuer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .cu_rd      (cu_rd),
        .cu_in_data (cu_in_data),
        .cu_out_v   (cu_out_v),
        .cu_out_rd  (cu_out_rd),
        .cu_out_data(cu_out_data),
        .busy       (busy),
        .stray_cnt  (stray_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard {err, data}, issue log and protocol counters.
    logic [32:0] exp_q[$];
    int unsigned iss_cyc[$];
    logic [4:0]  iss_rd[$];
    logic [31:0] iss_data[$];
    int unsigned rsp_seen = 0;
    int unsigned rsp_hs = 0;
    int unsigned rise_cyc = 0;
    int unsigned bad_pulse = 0;
    int unsigned bad_idle = 0;

    initial begin
        logic [32:0] e;
        logic        prev_valid;
        logic [4:0]  prev_rd;
        prev_valid = 1'b0;
        prev_rd    = 5'd31;
        forever begin
            @(negedge clk);
            if (cu_rd != 5'd31) begin
                iss_cyc.push_back(cyc);
                iss_rd.push_back(cu_rd);
                iss_data.push_back(cu_in_data);
                if (prev_rd != 5'd31 || cu_rd > 5'd1) bad_pulse++;
            end else if (cu_in_data != 32'd0) begin
                bad_idle++;
            end
            prev_rd = cu_rd;
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rsp_valid;
            if (rsp_valid) rsp_seen++;
            if (rsp_valid && rsp_ready) begin
                rsp_hs++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e[31:0]);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
                end
            end
        end
    end

    // Heap unit model: pushes on rd=0, replies with the max after `lat` cycles on rd=1.
    logic [31:0] mdl_heap[$];
    int          lat = 2;
    bit          stall = 1'b0;

    initial begin
        int          mi;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            if (reset) begin
                mdl_heap.delete();
            end else if (cu_rd == 5'd0) begin
                mdl_heap.push_back(cu_in_data);
            end else if (cu_rd == 5'd1 && !stall && mdl_heap.size() != 0) begin
                mi = 0;
                for (int i = 1; i < mdl_heap.size(); i++)
                    if (mdl_heap[i] > mdl_heap[mi]) mi = i;
                v = mdl_heap[mi];
                mdl_heap.delete(mi);
                repeat (lat) @(posedge clk);
                #1;
                mdl_v = 1'b1; mdl_rd = 5'd1; mdl_data = v;
                @(posedge clk);
                #1;
                mdl_v = 1'b0; mdl_rd = 5'd0; mdl_data = '0;
            end
        end
    end

    logic [31:0] ref_q[$];

    task automatic ref_take(output logic [31:0] v);
        int mi;
        mi = 0;
        for (int i = 1; i < ref_q.size(); i++)
            if (ref_q[i] > ref_q[mi]) mi = i;
        v = ref_q[mi];
        ref_q.delete(mi);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 after the write edge.
    task automatic send_cmd(input logic op, input logic [31:0] d, output int waits);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; waits = 0;
        @(negedge clk);
        while (!cmd_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_push(input logic [31:0] v, output int waits);
        ref_q.push_back(v);
        send_cmd(1'b0, v, waits);
    endtask

    task automatic drive_pop(input bit force_err);
        logic [31:0] v;
        int w;
        if (ref_q.size() == 0) begin
            exp_q.push_back({1'b1, 32'd0});
        end else begin
            ref_take(v);
            exp_q.push_back(force_err ? {1'b1, 32'd0} : {1'b0, v});
        end
        send_cmd(1'b1, 32'hFFFF_FFFF, w);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (busy || exp_q.size() != 0) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        iss_cyc.delete();
        iss_rd.delete();
        iss_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          n;
        int unsigned h0;
        int unsigned n0;
        logic [31:0] d0;
        int unsigned hold_bad;
        logic [31:0] push_vals[3];
        push_vals[0] = 32'd5; push_vals[1] = 32'd9; push_vals[2] = 32'd3;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_cu_rd", {27'd0, cu_rd}, 32'd31);
        check("rst_cu_in_data", cu_in_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stray", {24'd0, stray_cnt}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back pushes: one-cycle rd=0 pulses spaced 2+SETTLE_CYCLES apart.
        clear_log();
        h0 = rsp_seen;
        for (int i = 0; i < 3; i++) begin
            drive_push(push_vals[i], w);
            check($sformatf("push_ready_%0d", i), w, 32'd0);
        end
        wait_idle("push");
        check("push_issue_count", iss_cyc.size(), 32'd3);
        if (iss_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("push_rd_%0d", i), {27'd0, iss_rd[i]}, 32'd0);
                check($sformatf("push_data_%0d", i), iss_data[i], push_vals[i]);
            end
            check("push_spacing_01", iss_cyc[1] - iss_cyc[0], 32'd10);
            check("push_spacing_12", iss_cyc[2] - iss_cyc[1], 32'd10);
        end
        check("push_no_rsp", rsp_seen - h0, 32'd0);

        // Three pops drain the heap in descending order.
        clear_log();
        h0 = rsp_hs;
        for (int i = 0; i < 3; i++) drive_pop(1'b0);
        wait_idle("pop");
        check("pop_rsp_count", rsp_hs - h0, 32'd3);
        check("pop_issue_count", iss_cyc.size(), 32'd3);
        if (iss_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("pop_rd_%0d", i), {27'd0, iss_rd[i]}, 32'd1);
                check($sformatf("pop_in_data_%0d", i), iss_data[i], 32'd0);
            end
        end

        // Pop on empty heap times out after 16 WAIT_RSP cycles.
        clear_log();
        drive_pop(1'b0);
        wait_idle("empty");
        if (iss_cyc.size() == 1) check("empty_latency", rise_cyc - iss_cyc[0], 32'd17);
        else check("empty_issue_count", iss_cyc.size(), 32'd1);

        // Reply on the final counted cycle wins over the timeout.
        drive_push(32'h11, w);
        wait_idle("push11");
        lat = 16;
        clear_log();
        drive_pop(1'b0);
        wait_idle("lat16");
        if (iss_cyc.size() == 1) check("lat16_latency", rise_cyc - iss_cyc[0], 32'd17);
        else check("lat16_issue_count", iss_cyc.size(), 32'd1);
        check("lat16_stray", {24'd0, stray_cnt}, 32'd0);

        // One cycle later the reply misses the window: timeout plus one stray.
        lat = 17;
        drive_push(32'h12, w);
        wait_idle("push12");
        drive_pop(1'b1);
        wait_idle("lat17");
        check("lat17_stray", {24'd0, stray_cnt}, 32'd1);
        lat = 2;

        // Response held under back-pressure; queued push waits for the handshake.
        rsp_ready = 1'b0;
        drive_push(32'hDEADBEEF, w);
        drive_pop(1'b0);
        drive_push(32'd7, w);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_data", rsp_data, 32'hDEADBEEF);
        clear_log();
        d0 = rsp_data;
        hold_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || rsp_err) hold_bad++;
        end
        check("hold_stable", hold_bad, 32'd0);
        check("hold_no_issue", iss_cyc.size(), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("hold");
        check("hold_after_count", iss_cyc.size(), 32'd1);
        if (iss_cyc.size() == 1) begin
            check("hold_after_rd", {27'd0, iss_rd[0]}, 32'd0);
            check("hold_after_data", iss_data[0], 32'd7);
        end

        // Stalled pop, fill the FIFO, then reset asynchronously mid-WAIT_RSP.
        stall = 1'b1;
        clear_log();
        send_cmd(1'b1, 32'd0, w);
        n = 0;
        while (iss_cyc.size() == 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("stall_pop_issued", iss_cyc.size(), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, 32'd100 + i, w);
            check($sformatf("fill_ready_%0d", i), w, 32'd0);
        end
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 32'd200;
        @(negedge clk);
        check("fill_full_ready", {31'd0, cmd_ready}, 32'd0);
        check("fill_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cu_rd", {27'd0, cu_rd}, 32'd31);
        check("arst_cu_in_data", cu_in_data, 32'd0);
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_rsp_data", rsp_data, 32'd0);
        check("arst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("arst_stray", {24'd0, stray_cnt}, 32'd0);
        cmd_valid = 1'b0;
        exp_q.delete();
        ref_q.delete();
        stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n0 = iss_cyc.size();
        repeat (30) @(negedge clk);
        check("post_rst_no_issue", iss_cyc.size() - n0, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Unexpected replies while IDLE only bump the saturating stray counter.
        @(posedge clk);
        #1;
        h0 = rsp_seen;
        repeat (3) begin
            inj_v = 1'b1;
            @(posedge clk);
            #1;
            inj_v = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stray_three", {24'd0, stray_cnt}, 32'd3);
        check("stray_no_rsp", rsp_seen - h0, 32'd0);
        @(posedge clk);
        #1;
        inj_v = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        inj_v = 1'b0;
        @(negedge clk);
        check("stray_saturate", {24'd0, stray_cnt}, 32'd255);

        check("pulse_shape", bad_pulse, 32'd0);
        check("idle_in_data", bad_idle, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
